// File: rtl/gpio_seq_ctrl.sv
// GPIO pattern sequencer: plays a table of (out, dir, hold) entries onto the pins,
// and passes the software out/dir values through whenever it is not running.
module gpio_seq_ctrl #(
  parameter int GPIO_NUM   = 8,
  parameter int DEPTH      = 16,
  parameter int HOLD_WIDTH = 16,
  parameter int LOOP_WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cfg_we_i,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr_i,
  input  logic [GPIO_NUM-1:0]        cfg_out_i,
  input  logic [GPIO_NUM-1:0]        cfg_dir_i,
  input  logic [HOLD_WIDTH-1:0]      cfg_hold_i,
  input  logic [$clog2(DEPTH):0]     len_i,
  input  logic [LOOP_WIDTH-1:0]      loop_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic [GPIO_NUM-1:0]        sw_out_i,
  input  logic [GPIO_NUM-1:0]        sw_dir_i,
  output logic [GPIO_NUM-1:0]        gpio_out_o,
  output logic [GPIO_NUM-1:0]        gpio_dir_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(DEPTH)-1:0]   idx_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [GPIO_NUM-1:0]   out_q, out_d, dir_q, dir_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [HOLD_WIDTH-1:0] hold_q, hold_d;
  logic [LOOP_WIDTH-1:0] pass_q, pass_d, loop_q, loop_d;
  logic [LW-1:0]         len_q, len_d;

  logic [GPIO_NUM-1:0]   tbl_out  [DEPTH];
  logic [GPIO_NUM-1:0]   tbl_dir  [DEPTH];
  logic [HOLD_WIDTH-1:0] tbl_hold [DEPTH];

  logic          start_ok, entry_end, last_entry, finished;
  logic [AW-1:0] next_idx;

  // Table is only writable while idle so a running pattern never changes under us.
  always_ff @(posedge clk_i) begin
    if (cfg_we_i && state_q == S_IDLE) begin
      tbl_out[cfg_addr_i]  <= cfg_out_i;
      tbl_dir[cfg_addr_i]  <= cfg_dir_i;
      tbl_hold[cfg_addr_i] <= cfg_hold_i;
    end
  end

  assign start_ok   = start_i && !stop_i && (len_i != '0) && (len_i <= LW'(DEPTH));
  assign entry_end  = (hold_q == tbl_hold[idx_q]);
  assign last_entry = ({1'b0, idx_q} == (len_q - LW'(1)));
  // A pass completes on the last entry; compare one wider so loop=max still finishes.
  assign finished   = (loop_q != '0) &&
                      (({1'b0, pass_q} + (LOOP_WIDTH+1)'(1)) == {1'b0, loop_q});
  assign next_idx   = last_entry ? '0 : idx_q + AW'(1);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    idx_d   = idx_q;
    hold_d  = hold_q;
    pass_d  = pass_q;
    len_d   = len_q;
    loop_d  = loop_q;
    case (state_q)
      S_IDLE: begin
        out_d  = sw_out_i;
        dir_d  = sw_dir_i;
        busy_d = 1'b0;
        if (start_ok) begin
          state_d = S_RUN;
          len_d   = len_i;
          loop_d  = loop_i;
          out_d   = tbl_out[0];
          dir_d   = tbl_dir[0];
          idx_d   = '0;
          hold_d  = '0;
          pass_d  = '0;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (stop_i) begin
          state_d = S_IDLE;
          out_d   = sw_out_i;
          dir_d   = sw_dir_i;
          busy_d  = 1'b0;
          idx_d   = '0;
        end else if (entry_end) begin
          if (last_entry && finished) begin
            state_d = S_DONE;
            out_d   = sw_out_i;
            dir_d   = sw_dir_i;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d  = next_idx;
            hold_d = '0;
            out_d  = tbl_out[next_idx];
            dir_d  = tbl_dir[next_idx];
            // Infinite mode must not wrap the pass count back into a match.
            if (last_entry && pass_q != '1) pass_d = pass_q + LOOP_WIDTH'(1);
          end
        end else begin
          hold_d = hold_q + HOLD_WIDTH'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        out_d   = sw_out_i;
        dir_d   = sw_dir_i;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      dir_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
    end
  end

  // Run bookkeeping is always reloaded on start, so it needs no reset.
  always_ff @(posedge clk_i) begin
    hold_q <= hold_d;
    pass_q <= pass_d;
    len_q  <= len_d;
    loop_q <= loop_d;
  end

  assign gpio_out_o = out_q;
  assign gpio_dir_o = dir_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign idx_o      = idx_q;

endmodule

// File: doc/gpio_seq_ctrl.md
Name: gpio_seq_ctrl

Overview:
Pattern sequencer and pin-ownership controller for the GPIO bank (GPIO_NUM pins driving tri-state pads via out/dir). It holds a small table of (out, dir, hold) entries and plays them onto the pins with per-entry hold time and loop count. When idle it passes software-programmed out/dir values through. It sits between the APB GPIO register block and the pad ring.

Parameters:
GPIO_NUM, 8, number of GPIO pins
DEPTH, 16, pattern table entries (power of two, >=2)
HOLD_WIDTH, 16, width of per-entry hold count
LOOP_WIDTH, 8, width of loop count

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, synchronous, active-high
cfg_we_i  input  1  table write strobe
cfg_addr_i  input  $clog2(DEPTH)  table write index
cfg_out_i  input  GPIO_NUM  entry output value
cfg_dir_i  input  GPIO_NUM  entry direction (1 = drive)
cfg_hold_i  input  HOLD_WIDTH  entry hold; entry lasts hold+1 cycles
len_i  input  $clog2(DEPTH)+1  number of entries to play, 1..DEPTH
loop_i  input  LOOP_WIDTH  passes to play; 0 = infinite
start_i  input  1  start request
stop_i  input  1  abort request
sw_out_i  input  GPIO_NUM  software output value (pass-through)
sw_dir_i  input  GPIO_NUM  software direction (pass-through)
gpio_out_o  output  GPIO_NUM  pin output value
gpio_dir_o  output  GPIO_NUM  pin direction
busy_o  output  1  sequencer owns the pins
done_o  output  1  one-cycle pulse on normal completion
idx_o  output  $clog2(DEPTH)  current entry index

Behaviour:
- Reset: gpio_out_o=0, gpio_dir_o=0, busy_o=0, done_o=0, idx_o=0, state IDLE. Table contents not reset. Reset mid-run aborts immediately, no done pulse.
- All outputs registered. States: IDLE, RUN, DONE.
- IDLE: gpio_out_o/gpio_dir_o load sw_out_i/sw_dir_i every edge (1-cycle latency). cfg_we_i writes entry cfg_addr_i at the edge.
- IDLE, start_i=1, stop_i=0, len_i in 1..DEPTH: at that edge latch len and loop; load entry 0 onto gpio_out_o/gpio_dir_o; idx_o=0, hold counter=0, busy_o=1; go RUN. len_i=0 or >DEPTH: start ignored. start_i and stop_i together: stop wins, start ignored.
- RUN: entry k is driven for exactly hold_k+1 cycles. On the last cycle of entry k, the next edge loads entry k+1. After entry len-1, idx wraps to 0 and the pass count increments. If loop_i != 0 and the completed pass count reaches loop_i, the next edge goes to DONE instead.
- RUN: cfg_we_i is ignored (table write-protected). start_i is ignored. sw_* are ignored.
- RUN, stop_i=1: the next edge goes to IDLE, outputs load sw_* values, busy_o=0, no done pulse. stop takes precedence over entry advance and completion on the same edge.
- DONE: lasts one cycle with done_o=1, busy_o=0, and outputs loaded from sw_*. start_i is ignored. Unconditionally returns to IDLE.
- Infinite mode (loop_i=0) runs until stop_i or reset. The pass counter saturates and does not wrap into completion.
- Hold counter width is HOLD_WIDTH. hold = 2^HOLD_WIDTH-1 gives 2^HOLD_WIDTH cycles, no overflow.

Test Plan:
- Reset: assert rst_i 4 cycles mid-RUN -> next edge gpio_out_o=0, gpio_dir_o=0, busy_o=0, done_o=0, idx_o=0.
- Pass-through: IDLE, sw_out_i=8'hA5, sw_dir_i=8'hFF -> one edge later gpio_out_o=8'hA5, gpio_dir_o=8'hFF. Pass-through is ignored while busy_o=1.
- Single pass: entries {01,FF,h=0},{02,FF,h=2},{04,0F,h=1}, len=3, loop=1, start pulse -> out 01 for 1 cycle, 02 for 3, 04/dir 0F for 2. Then done_o=1 for exactly 1 cycle, busy_o high 6 cycles total.
- Looping: same table, loop=2 -> sequence 01,02,02,02,04,04 repeated twice (12 busy cycles), idx_o wraps 2->0, single done pulse.
- Abort and contention: loop=0, stop_i at cycle 20 -> the next edge gives busy_o=0, outputs=sw values, no done pulse. start_i+stop_i together in IDLE -> remains IDLE. cfg_we_i during RUN -> table unchanged on the next run.
- Illegal start and boundaries: len_i=0 start -> stays IDLE. len=DEPTH=16, all hold=0, loop=1 -> 16 cycles busy, idx_o 0..15. A start during DONE is ignored.
